// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   ID-stage initiator for the branch-condition compare path. It decodes a
//   branch, stalls the front end until the register operands it needs are
//   final, drives the shared signed comparator and publishes a one-cycle
//   resolution (taken, next_pc, flush). It also counts stall cycles
//   (saturating) for performance monitoring.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   valid_in              branch present in ID this cycle
//   opcode, rt_field      instruction[31:26] and instruction[20:16]
//   imm16, pc4            branch offset and branch address + 4
//   rs_val, rt_val        forwarded register values
//   rs_ready, rt_ready    forwarded value is final
//   cmp_a, cmp_b, cmp_s   registered operands/code to the comparator
//   cmp_out               comparator verdict (combinational from cmp_*)
//   stall                 freeze IF/ID (combinational)
//   resolve_valid         one-cycle resolution strobe
//   taken, next_pc, flush resolution payload, valid with resolve_valid
//   illegal               one-cycle pulse for a non-branch opcode
//   stall_cycles          saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [15:0] imm16,
  input  logic [31:0] pc4,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rs_ready,
  input  logic        rt_ready,
  output logic [31:0] cmp_a,
  output logic [31:0] cmp_b,
  output logic [2:0]  cmp_s,
  input  logic        cmp_out,
  output logic        stall,
  output logic        resolve_valid,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        flush,
  output logic        illegal,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] CMP_EQ = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_LE = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] cmp_a_q, cmp_a_d;
  logic [31:0] cmp_b_q, cmp_b_d;
  logic [2:0]  cmp_s_q, cmp_s_d;
  logic [2:0]  sel_s_q, sel_s_d;       // compare code held while waiting
  logic        inv_q, inv_d;
  logic        needs_rt_q, needs_rt_d;
  logic [15:0] imm16_q, imm16_d;
  logic [31:0] pc4_q, pc4_d;
  logic        resolve_valid_q, resolve_valid_d;
  logic        taken_q, taken_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        flush_q, flush_d;
  logic        illegal_q, illegal_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic        dec_legal_s;
  logic [2:0]  dec_s_s;
  logic        dec_inv_s;
  logic        dec_needs_rt_s;
  logic        accept_s;
  logic        acc_ready_s;
  logic        wait_ready_s;
  logic        take_s;
  logic [31:0] target_s;
  logic        stall_s;

  // Decode the incoming instruction into compare code, inversion and operand needs.
  always_comb begin
    dec_legal_s    = 1'b0;
    dec_s_s        = CMP_EQ;
    dec_inv_s      = 1'b0;
    dec_needs_rt_s = 1'b0;
    case (opcode)
      6'b000100: begin // beq
        dec_legal_s    = 1'b1;
        dec_needs_rt_s = 1'b1;
      end
      6'b000101: begin // bne: equality compare, inverted
        dec_legal_s    = 1'b1;
        dec_inv_s      = 1'b1;
        dec_needs_rt_s = 1'b1;
      end
      6'b000111: begin // bgtz
        dec_legal_s = 1'b1;
        dec_s_s     = CMP_GT;
      end
      6'b000110: begin // blez
        dec_legal_s = 1'b1;
        dec_s_s     = CMP_LE;
      end
      6'b000001: begin // REGIMM: rt_field picks the variant
        case (rt_field)
          5'b00001: begin // bgez
            dec_legal_s = 1'b1;
            dec_s_s     = CMP_GE;
          end
          5'b00000: begin // bltz
            dec_legal_s = 1'b1;
            dec_s_s     = CMP_LT;
          end
          default: begin
            dec_legal_s = 1'b0;
          end
        endcase
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Handshake terms shared by the next-state logic and the stall output.
  always_comb begin
    accept_s     = valid_in & ((state_q == S_IDLE) | (state_q == S_DONE));
    acc_ready_s  = rs_ready & (rt_ready | ~dec_needs_rt_s);
    wait_ready_s = rs_ready & (rt_ready | ~needs_rt_q);
    take_s       = cmp_out ^ inv_q;
    target_s     = pc4_q + {{14{imm16_q[15]}}, imm16_q, 2'b00};
    stall_s      = (accept_s & dec_legal_s) | (state_q == S_WAIT) | (state_q == S_EVAL);
  end

  // Next-state and next-output computation for the branch resolution FSM.
  always_comb begin
    state_d         = state_q;
    cmp_a_d         = cmp_a_q;
    cmp_b_d         = cmp_b_q;
    cmp_s_d         = cmp_s_q;
    sel_s_d         = sel_s_q;
    inv_d           = inv_q;
    needs_rt_d      = needs_rt_q;
    imm16_d         = imm16_q;
    pc4_d           = pc4_q;
    // Resolution payload is a one-cycle strobe, zero whenever not resolving.
    resolve_valid_d = 1'b0;
    taken_d         = 1'b0;
    next_pc_d       = 32'h0000_0000;
    flush_d         = 1'b0;
    illegal_d       = accept_s & ~dec_legal_s;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s && dec_legal_s) begin
          sel_s_d    = dec_s_s;
          inv_d      = dec_inv_s;
          needs_rt_d = dec_needs_rt_s;
          imm16_d    = imm16;
          pc4_d      = pc4;
          if (acc_ready_s) begin
            cmp_a_d = rs_val;
            cmp_b_d = dec_needs_rt_s ? rt_val : 32'h0000_0000;
            cmp_s_d = dec_s_s;
            state_d = S_EVAL;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Live forwarded values are used; there is deliberately no timeout.
        if (wait_ready_s) begin
          cmp_a_d = rs_val;
          cmp_b_d = needs_rt_q ? rt_val : 32'h0000_0000;
          cmp_s_d = sel_s_q;
          state_d = S_EVAL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_EVAL: begin
        resolve_valid_d = 1'b1;
        taken_d         = take_s;
        flush_d         = take_s;
        next_pc_d       = take_s ? target_s : pc4_q;
        state_d         = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stall_s && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State and registered outputs, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cmp_a_q         <= 32'h0000_0000;
      cmp_b_q         <= 32'h0000_0000;
      cmp_s_q         <= 3'b000;
      sel_s_q         <= 3'b000;
      inv_q           <= 1'b0;
      needs_rt_q      <= 1'b0;
      imm16_q         <= 16'h0000;
      pc4_q           <= 32'h0000_0000;
      resolve_valid_q <= 1'b0;
      taken_q         <= 1'b0;
      next_pc_q       <= 32'h0000_0000;
      flush_q         <= 1'b0;
      illegal_q       <= 1'b0;
      stall_cycles_q  <= 16'h0000;
    end else begin
      state_q         <= state_d;
      cmp_a_q         <= cmp_a_d;
      cmp_b_q         <= cmp_b_d;
      cmp_s_q         <= cmp_s_d;
      sel_s_q         <= sel_s_d;
      inv_q           <= inv_d;
      needs_rt_q      <= needs_rt_d;
      imm16_q         <= imm16_d;
      pc4_q           <= pc4_d;
      resolve_valid_q <= resolve_valid_d;
      taken_q         <= taken_d;
      next_pc_q       <= next_pc_d;
      flush_q         <= flush_d;
      illegal_q       <= illegal_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign cmp_a         = cmp_a_q;
  assign cmp_b         = cmp_b_q;
  assign cmp_s         = cmp_s_q;
  assign stall         = stall_s;
  assign resolve_valid = resolve_valid_q;
  assign taken         = taken_q;
  assign next_pc       = next_pc_q;
  assign flush         = flush_q;
  assign illegal       = illegal_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//   Directed and randomized checks of branch_unit against a behavioural model
//   of branch semantics (signed compares, target arithmetic, resolution
//   latency of readiness + 2 cycles). The shared comparator is modelled here.
// -----------------------------------------------------------------------------
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [5:0]  opcode;
  logic [4:0]  rt_field;
  logic [15:0] imm16;
  logic [31:0] pc4;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_ready;
  logic        rt_ready;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_s;
  logic        cmp_out;
  logic        stall;
  logic        resolve_valid;
  logic        taken;
  logic [31:0] next_pc;
  logic        flush;
  logic        illegal;
  logic [15:0] stall_cycles;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_sc = 16'h0000;

  branch_unit dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .rt_field(rt_field), .imm16(imm16), .pc4(pc4), .rs_val(rs_val),
    .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_s(cmp_s), .cmp_out(cmp_out),
    .stall(stall), .resolve_valid(resolve_valid), .taken(taken),
    .next_pc(next_pc), .flush(flush), .illegal(illegal),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Shared signed comparator.
  always_comb begin
    case (cmp_s)
      3'b000:  cmp_out = (cmp_a == cmp_b);
      3'b001:  cmp_out = ($signed(cmp_a) >  $signed(cmp_b));
      3'b010:  cmp_out = ($signed(cmp_a) <  $signed(cmp_b));
      3'b011:  cmp_out = ($signed(cmp_a) >= $signed(cmp_b));
      3'b100:  cmp_out = ($signed(cmp_a) <= $signed(cmp_b));
      default: cmp_out = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rtf,
                       input logic [15:0] imm, input logic [31:0] p4,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr);
    valid_in = v; opcode = op; rt_field = rtf; imm16 = imm; pc4 = p4;
    rs_val = rs; rt_val = rt; rs_ready = rsr; rt_ready = rtr;
  endtask

  // Branch semantics: taken verdict, compare code and whether rt is used.
  task automatic model(input logic [5:0] op, input logic [4:0] rtf,
                       input logic [31:0] rs, input logic [31:0] rt,
                       output logic tk, output logic [2:0] s, output logic use_rt);
    int srs;
    srs = int'(rs);
    tk = 1'b0; s = 3'd0; use_rt = 1'b0;
    if (op == 6'd4) begin tk = (rs == rt); s = 3'd0; use_rt = 1'b1; end
    else if (op == 6'd5) begin tk = (rs != rt); s = 3'd0; use_rt = 1'b1; end
    else if (op == 6'd7) begin tk = (srs > 0);  s = 3'd1; end
    else if (op == 6'd6) begin tk = (srs <= 0); s = 3'd4; end
    else if (op == 6'd1 && rtf == 5'd1) begin tk = (srs >= 0); s = 3'd3; end
    else if (op == 6'd1 && rtf == 5'd0) begin tk = (srs < 0);  s = 3'd2; end
    else begin tk = 1'b0; end
  endtask

  // Runs one legal branch: rs/rt become ready at cycles rs_d/rt_d after accept.
  task automatic do_branch(input string tag, input logic [5:0] op, input logic [4:0] rtf,
                           input logic [15:0] imm, input logic [31:0] p4,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input int rs_d, input int rt_d);
    logic        tk, use_rt;
    logic [2:0]  s;
    logic [31:0] exp_npc;
    int          k, res_c, stalls;
    bit          seen;
    model(op, rtf, rs, rt, tk, s, use_rt);
    k = rs_d;
    if (use_rt && rt_d > k) k = rt_d;
    exp_npc = tk ? p4 + 32'(int'($signed(imm)) * 4) : p4;
    seen = 1'b0; res_c = -1; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      drive(c == 0, op, rtf, imm, p4, rs, rt, c >= rs_d, c >= rt_d);
      @(negedge clk);
      if (stall) stalls++;
      if (seen) begin
        check({tag, " strobe_len"}, resolve_valid, 1'b0);
        check({tag, " stall_cnt"}, 32'(stalls), 32'(k + 2));
        exp_sc = exp_sc + 16'(k + 2);
        check({tag, " stall_cycles"}, stall_cycles, exp_sc);
        tick();
        break;
      end
      if (resolve_valid) begin
        seen = 1'b1; res_c = c;
        check({tag, " latency"}, 32'(res_c), 32'(k + 2));
        check({tag, " taken"}, taken, tk);
        check({tag, " flush"}, flush, tk);
        check({tag, " next_pc"}, next_pc, exp_npc);
        check({tag, " cmp_s"}, cmp_s, s);
        check({tag, " cmp_a"}, cmp_a, rs);
        check({tag, " cmp_b"}, cmp_b, use_rt ? rt : 32'h0);
      end
      tick();
    end
    if (!seen) check({tag, " timeout"}, 32'(seen), 32'd1);
  endtask

  // Presents a non-branch opcode for one cycle.
  task automatic do_illegal(input string tag, input logic [5:0] op, input logic [4:0] rtf);
    drive(1'b1, op, rtf, 16'h0010, 32'h100, 32'h1, 32'h1, 1'b1, 1'b1);
    @(negedge clk);
    check({tag, " stall"}, stall, 1'b0);
    tick();
    drive(1'b0, 6'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check({tag, " pulse"}, illegal, 1'b1);
    check({tag, " no_resolve"}, resolve_valid, 1'b0);
    tick();
    @(negedge clk);
    check({tag, " pulse_end"}, illegal, 1'b0);
    check({tag, " no_resolve2"}, resolve_valid, 1'b0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " cmp_a"}, cmp_a, 32'h0);
    check({tag, " cmp_b"}, cmp_b, 32'h0);
    check({tag, " cmp_s"}, cmp_s, 3'd0);
    check({tag, " taken"}, taken, 1'b0);
    check({tag, " next_pc"}, next_pc, 32'h0);
    check({tag, " resolve"}, resolve_valid, 1'b0);
    check({tag, " flush"}, flush, 1'b0);
    check({tag, " illegal"}, illegal, 1'b0);
    check({tag, " stall_cycles"}, stall_cycles, 16'h0);
    check({tag, " stall"}, stall, 1'b0);
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [4:0]  rtfs[6];
    logic [31:0] corner[4];
    int          strobes;
    ops  = '{6'd4, 6'd5, 6'd7, 6'd6, 6'd1, 6'd1};
    rtfs = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0};
    corner = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    reset = 1'b1;
    drive(1'b0, 6'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Directed cases
    do_branch("bne_wait", 6'd5, 5'd0, 16'h0040, 32'h0000_1000, 32'd5, 32'd5, 0, 3);
    do_branch("beq", 6'd4, 5'd0, 16'h0003, 32'h0040_0008, 32'h1234, 32'h1234, 0, 0);
    do_branch("blez", 6'd6, 5'd0, 16'h0010, 32'h2000, 32'h8000_0000, 32'h55, 0, 2);
    do_branch("bgtz0", 6'd7, 5'd0, 16'h0010, 32'h2000, 32'h0, 32'h0, 1, 0);
    do_branch("bltz", 6'd1, 5'd0, 16'h0010, 32'h2000, 32'hFFFF_FFFF, 32'h0, 0, 5);
    do_branch("bgez0", 6'd1, 5'd1, 16'h0010, 32'h2000, 32'h0, 32'h0, 2, 0);
    do_branch("wrap", 6'd4, 5'd0, 16'hFFFE, 32'h0000_0004, 32'h9, 32'h9, 0, 0);
    do_illegal("lw", 6'b100011, 5'd0);
    do_illegal("regimm_bad", 6'b000001, 5'b00010);

    // Back-to-back: second branch accepted in the first one's DONE cycle.
    drive(1'b1, 6'd4, 5'd0, 16'h0001, 32'h100, 32'h7, 32'h7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 6'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd5, 5'd0, 16'hFFFF, 32'h200, 32'h1, 32'h2, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b first_resolve", resolve_valid, 1'b1);
    check("b2b first_next_pc", next_pc, 32'h104);
    check("b2b stall_in_done", stall, 1'b1);
    tick();
    drive(1'b0, 6'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b gap", resolve_valid, 1'b0);
    tick();
    @(negedge clk);
    check("b2b second_resolve", resolve_valid, 1'b1);
    check("b2b second_taken", taken, 1'b1);
    check("b2b second_next_pc", next_pc, 32'h1FC);
    check("b2b stall_low", stall, 1'b0);
    tick();
    exp_sc = exp_sc + 16'd4;
    @(negedge clk);
    check("b2b stall_cycles", stall_cycles, exp_sc);
    tick();

    // Randomized branches against the model.
    for (int i = 0; i < 40; i++) begin
      int          sel;
      logic [31:0] rs, rt;
      sel = $urandom_range(0, 5);
      rs  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rt  = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      do_branch($sformatf("rand%0d", i), ops[sel], rtfs[sel], 16'($urandom),
                $urandom, rs, rt, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting: the pending branch is dropped.
    drive(1'b1, 6'd4, 5'd0, 16'h0004, 32'h300, 32'h3, 32'h3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 6'd4, 5'd0, 16'h0004, 32'h300, 32'h3, 32'h3, 1'b1, 1'b0);
    @(negedge clk);
    check("rstwait stall", stall, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 6'd4, 5'd0, 16'h0004, 32'h300, 32'h3, 32'h3, 1'b1, 1'b1);
    @(negedge clk);
    check_zero("rstwait");
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (resolve_valid) strobes++;
    end
    check("rstwait no_strobe", 32'(strobes), 32'd0);
    check("rstwait stall_cycles", stall_cycles, 16'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
